// File: rtl/sm_result_fifo_if.sv
// Handshake bundle between the stack machine, the result FIFO and its consumer.
// The FIFO itself takes the slave view.
interface sm_result_fifo_if #(
    parameter int DW = 20
);
    logic          d_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport master (
        output d_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  d_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/sm_result_fifo.sv
// First-word-fall-through result queue behind the stack machine, with sticky
// overflow, a wrapping accepted-result counter and a registered done flag.
module sm_result_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fin,
    sm_result_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [9:0]               res_cnt,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count_next;
    logic          pop;
    logic          push_ok;

    assign empty         = (count == '0);
    assign full          = (count == (AW+1)'(DEPTH));
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rp];

    // A full queue still takes a word when the head leaves in the same cycle.
    assign pop     = !empty & bus.out_ready;
    assign push_ok = bus.d_valid & (!full | pop);

    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + (AW+1)'(1);
        else if (pop && !push_ok)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            res_cnt  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            count <= count_next;
            done  <= fin & (count_next == '0) & !bus.d_valid;
            if (push_ok) begin
                wp      <= wp + AW'(1);
                res_cnt <= res_cnt + 10'd1;
            end
            if (pop)
                rp <= rp + AW'(1);
            if (bus.d_valid && !push_ok)
                overflow <= 1'b1;
        end
    end

    // Storage is left unreset; its contents are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= bus.in_data;
    end
endmodule

// File: doc/sm_result_fifo.md
# sm_result_fifo

Result buffer that sits directly downstream of the stack machine. It captures every arithmetic result the stack machine flags with `d_valid`, queues the results in order, and presents them to a consumer through a valid/ready handshake. It also tracks an overflow error, a wrapping result count, and a `done` indication, so the bench or display stage can tell when the program has finished and every result has been drained.

## Interface

Parameters:
- `DEPTH`, 8: number of queue entries. Must be a power of two, at least 2.
- `DW`, 20: data width. Matches the stack machine's `out_data`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `d_valid`  in  1  stack machine result strobe; one cycle per result.
- `in_data`  in  DW  stack machine `out_data`; sampled only when `d_valid=1`.
- `fin`  in  1  stack machine `fin` level (pc == program length).
- `out_valid`  out  1  queue head is valid.
- `out_data`  out  DW  queue head; 0 when empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky; a result was dropped.
- `res_cnt`  out  10  total results accepted, modulo 1024.
- `done`  out  1  `fin` is seen and the queue is drained.

## Operation

- Storage is a circular buffer of DEPTH × DW registers with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits.
- Both pointers wrap from DEPTH-1 to 0. Occupancy is held in `count`; full and empty are derived from `count`, never from pointer equality.
- Push request is `d_valid`. Pop is `out_valid & out_ready`.
- Push is accepted when `!full`, or when `full` and a pop occurs in the same cycle.
- Accepted push:
  - `mem[wp] <= in_data`, then `wp` increments.
  - `res_cnt` increments; it wraps from 1023 to 0.
- Rejected push (full and no pop):
  - Data is discarded; `wp` and `count` are unchanged.
  - `overflow` is set to 1 and stays 1 until reset.
- Pop: `rp` increments.
- Count update:
  - Push and pop in the same cycle: `count` is unchanged.
  - Push only: `count` increments.
  - Pop only: `count` decrements.
- `out_ready` while empty has no effect.
- The buffer is first-word-fall-through: `out_data = mem[rp]` and `out_valid = !empty`. Both are combinational from registered state.
- There is no empty bypass. A push into an empty queue becomes visible on the following cycle, even if `out_ready=1`.
- `out_data` is driven to 0 whenever empty.
- `done` is registered. Its next value is `fin & (count_next == 0) & !d_valid`.
  - It deasserts in the cycle after any of those terms goes false.
  - Example: a new program restarts and `fin` drops.
- `in_data` is ignored when `d_valid=0`.
- `fin` is used only for `done`.

## Timing

- Reset (asynchronous assert, any cycle, including mid-transfer):
  - `wp`, `rp`, `count`, `res_cnt` go to 0; `overflow` and `done` go to 0.
  - Outputs become `out_valid=0`, `out_data=0`, `empty=1`, `full=0`, `count=0`.
  - Memory contents are not reset; they are unobservable while empty.
- Reset release: the first push is accepted on the first rising edge with `rst_n=1`.
- Latency: `d_valid` high at edge N puts the word at the head after edge N if the queue was empty; `out_valid=1` in cycle N+1.
- Throughput: one push and one pop per cycle, sustained, at any occupancy including full.
- `count`, `full`, `empty`, `overflow` and `res_cnt` update on the same edge as the push or pop that changes them.
- `done` lags its condition by one cycle.
- The consumer must hold `out_ready` as a level. The block never withdraws `out_valid` without a pop, and `out_data` is stable while `out_valid=1` and no pop occurs.

## Test plan

- Reset, then push 5, -3 (0xFFFFD), 7 with `out_ready=0` → `count=3`, `out_valid=1`, `out_data=5`, `res_cnt=3`. Then hold `out_ready=1` → 5, 0xFFFFD, 7 on three consecutive cycles, then `empty=1`, `out_data=0`.
- Push 9 words with DEPTH=8 and `out_ready=0` → `full=1` after the 8th word, 9th word dropped, `overflow=1`, `res_cnt=8`. Drain → words 1..8 in order; `overflow` stays 1.
- At full, assert `d_valid` and `out_ready` together for 4 cycles → `count` stays 8, `overflow=0`, output order preserved, `res_cnt` +4.
- Pointer wrap: stream 20 words with pushes and pops interleaved so occupancy varies between 0 and 8 → every word is output exactly once, in order; `count` matches a reference model every cycle.
- Push 1 word, then raise `fin` → `done=0` while the word is queued. Pop it → `done=1` one cycle later. Drop `fin` → `done=0` the next cycle.
- Assert `rst_n=0` mid-cycle with `count=5` and `overflow=1` → all outputs go to reset values immediately, without waiting for a clock edge. After release, push 42 → head is 42, `res_cnt=1`.
